// File: rtl/trap_unit.sv
// trap_unit: M-mode trap responder with trap CSRs, registered one-cycle redirect and 64-bit mcycle.
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MEPC_MASK   = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req_valid,
    input  logic        trap_req_mode,
    input  logic [31:0] trap_req_cause,
    input  logic [31:0] trap_req_pc,
    input  logic [31:0] trap_req_tval,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirflag,
    output logic [31:0] redir_pc,
    output logic        mie_o
);
    typedef enum logic {IDLE, REDIR} state_t;
    state_t      state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, redir_pc_q, redir_pc_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic        accept, wr;
    logic [31:0] wval;

    assign accept    = (state_q == IDLE) && trap_req_valid;
    assign wr        = (csr_op != 2'b00) && !accept;
    assign redirflag = (state_q == REDIR);
    assign redir_pc  = redir_pc_q;
    assign mie_o     = mie_q;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            default: csr_rdata = 32'h0;
        endcase
    end

    assign wval = csr_op == 2'b01 ? csr_wdata :
                  csr_op == 2'b10 ? csr_rdata | csr_wdata : csr_rdata & ~csr_wdata;

    always_comb begin
        state_d    = accept ? REDIR : IDLE;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        redir_pc_d = redir_pc_q;
        mcycle_d   = mcycle_q + 64'd1;
        if (wr) begin
            case (csr_addr)
                12'h300: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                12'h305: mtvec_d    = {wval[31:2], 2'b00};
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval & MEPC_MASK;
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
                default: ;
            endcase
        end
        if (accept) begin
            if (!trap_req_mode) begin
                mepc_d     = trap_req_pc & MEPC_MASK;
                mcause_d   = trap_req_cause;
                mtval_d    = trap_req_tval;
                mpie_d     = mie_q;
                mie_d      = 1'b0;
                redir_pc_d = mtvec_q;
            end else begin
                mie_d      = mpie_q;
                mpie_d     = 1'b1;
                redir_pc_d = mepc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            redir_pc_q <= 32'h0;
            mcycle_q   <= 64'h0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            redir_pc_q <= redir_pc_d;
            mcycle_q   <= mcycle_d;
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed-vector bench for trap_unit with hand-computed expectations.
module tb_trap_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        trap_req_valid = 1'b0, trap_req_mode = 1'b0;
    logic [31:0] trap_req_cause = '0, trap_req_pc = '0, trap_req_tval = '0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata, redir_pc;
    logic        redirflag, mie_o;
    int          checks = 0, errors = 0;
    logic [31:0] v, lo;

    trap_unit dut (
        .clk(clk), .rst(rst), .trap_req_valid(trap_req_valid), .trap_req_mode(trap_req_mode),
        .trap_req_cause(trap_req_cause), .trap_req_pc(trap_req_pc), .trap_req_tval(trap_req_tval),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .redirflag(redirflag), .redir_pc(redir_pc), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        csr_op   = 2'b00;
        #1;
        d = csr_rdata;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        tick();
        csr_op    = 2'b00;
    endtask

    task automatic req(input logic mode, input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        trap_req_valid = 1'b1;
        trap_req_mode  = mode;
        trap_req_cause = cause;
        trap_req_pc    = pc;
        trap_req_tval  = tval;
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();
        check("rst_redirflag", redirflag, 0);
        check("rst_redir_pc", redir_pc, 0);
        check("rst_mie", mie_o, 0);
        chk_csr("rst_mstatus", 12'h300, 32'h1800);
        chk_csr("rst_mtvec", 12'h305, 0);
        chk_csr("unmapped_read", 12'h123, 0);

        wr(12'h305, 2'b01, 32'h103);
        chk_csr("mtvec_mask", 12'h305, 32'h100);
        req(1'b0, 32'd11, 32'h40, 32'h0);
        tick();
        trap_req_valid = 1'b0;
        check("ecall_flag", redirflag, 1);
        check("ecall_pc", redir_pc, 32'h100);
        chk_csr("ecall_mepc", 12'h341, 32'h40);
        chk_csr("ecall_mcause", 12'h342, 32'd11);
        tick();
        check("ecall_flag_off", redirflag, 0);

        wr(12'h300, 2'b10, 32'h8);
        check("mie_set", mie_o, 1);
        req(1'b0, 32'd4, 32'h86, 32'h1001);
        tick();
        trap_req_valid = 1'b0;
        check("mis_flag", redirflag, 1);
        chk_csr("mis_mepc", 12'h341, 32'h84);
        chk_csr("mis_mtval", 12'h343, 32'h1001);
        chk_csr("mis_mstatus", 12'h300, 32'h1880);
        check("mis_mie", mie_o, 0);
        tick();
        req(1'b1, 32'd0, 32'h90, 32'h0);
        tick();
        trap_req_valid = 1'b0;
        check("mret_flag", redirflag, 1);
        check("mret_pc", redir_pc, 32'h84);
        chk_csr("mret_mstatus", 12'h300, 32'h1888);
        check("mret_mie", mie_o, 1);
        chk_csr("mret_mcause", 12'h342, 32'd4);
        tick();

        req(1'b0, 32'd3, 32'h200, 32'h55);
        tick();
        check("b2b_flag1", redirflag, 1);
        req(1'b0, 32'd7, 32'h300, 32'h66);
        csr_addr  = 12'h340;
        csr_op    = 2'b01;
        csr_wdata = 32'h1234;
        tick();
        csr_op = 2'b00;
        trap_req_valid = 1'b0;
        check("b2b_flag2", redirflag, 0);
        chk_csr("b2b_mepc", 12'h341, 32'h200);
        chk_csr("b2b_mcause", 12'h342, 32'd3);
        chk_csr("b2b_mtval", 12'h343, 32'h55);
        chk_csr("redir_csr_write", 12'h340, 32'h1234);
        tick();
        check("b2b_flag3", redirflag, 0);

        req(1'b0, 32'd11, 32'h500, 32'h0);
        csr_addr  = 12'h341;
        csr_op    = 2'b01;
        csr_wdata = 32'hDEAD_BEEC;
        #1;
        check("collide_rdata_old", csr_rdata, 32'h200);
        tick();
        csr_op = 2'b00;
        trap_req_valid = 1'b0;
        check("collide_flag", redirflag, 1);
        check("collide_pc", redir_pc, 32'h100);
        chk_csr("collide_mepc", 12'h341, 32'h500);
        tick();

        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        chk_csr("mcyc_lo_wr", 12'hB00, 32'hFFFF_FFFF);
        chk_csr("mcyc_hi_hold", 12'hB80, 32'h0);
        tick();
        chk_csr("mcyc_lo_wrap", 12'hB00, 32'h0);
        chk_csr("mcyc_hi_carry", 12'hB80, 32'h1);
        rd(12'hB00, lo);
        wr(12'hB80, 2'b01, 32'hABCD);
        chk_csr("mcych_wr", 12'hB80, 32'hABCD);
        chk_csr("mcych_lo_hold", 12'hB00, lo);
        tick();
        chk_csr("mcych_lo_count", 12'hB00, lo + 32'd1);
        chk_csr("mcych_hi_keep", 12'hB80, 32'hABCD);

        req(1'b0, 32'd2, 32'h600, 32'h9);
        tick();
        trap_req_valid = 1'b0;
        check("pre_rst_flag", redirflag, 1);
        rst = 1'b1;
        #1;
        check("arst_flag", redirflag, 0);
        check("arst_pc", redir_pc, 0);
        check("arst_mie", mie_o, 0);
        chk_csr("arst_mstatus", 12'h300, 32'h1800);
        chk_csr("arst_mtvec", 12'h305, 0);
        chk_csr("arst_mepc", 12'h341, 0);
        chk_csr("arst_mcause", 12'h342, 0);
        chk_csr("arst_mtval", 12'h343, 0);
        chk_csr("arst_mscratch", 12'h340, 0);
        chk_csr("arst_mcycle", 12'hB00, 0);
        chk_csr("arst_mcycleh", 12'hB80, 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_flag1", redirflag, 0);
        tick();
        check("post_rst_flag2", redirflag, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Machine-mode trap responder for the EX-stage trap request interface.
- Accepts trap requests (ECALL, EBREAK, MRET, load/store misalign) and updates the M-mode trap CSRs.
- Returns a registered one-cycle redirect (redirflag plus target PC) that drives the branch unit's PC source and the pipeline flush.
- Also serves the CSR read/write port for its CSRs and a free-running 64-bit mcycle counter.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (direct mode; bits [1:0] always 0)
MEPC_MASK, 32'hFFFF_FFFC, mask applied to every mepc write

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
trap_req_valid  input  1  trap request valid (EX stage)
trap_req_mode  input  1  0 = TRAP_ENTER, 1 = TRAP_RETURN
trap_req_cause  input  32  mcause value (ENTER only)
trap_req_pc  input  32  PC of faulting/returning instruction
trap_req_tval  input  32  mtval value (ENTER only)
csr_addr  input  12  CSR address
csr_op  input  2  00 none, 01 RW, 10 RS, 11 RC
csr_wdata  input  32  CSR write operand
csr_rdata  output  32  combinational read of csr_addr (old value); 0 for unmapped addresses
redirflag  output  1  registered redirect/flush pulse
redir_pc  output  32  registered redirect target, valid while redirflag=1
mie_o  output  1  current mstatus.MIE

Behaviour:
- CSR map:
  - mstatus 0x300: MIE bit3 and MPIE bit7 are R/W; MPP [12:11] reads 2'b11 and is read-only; all other bits read 0.
  - mtvec 0x305: bits [1:0] forced 0.
  - mscratch 0x340.
  - mepc 0x341: masked by MEPC_MASK.
  - mcause 0x342, mtval 0x343.
  - mcycle 0xB00, mcycleh 0xB80.
  - Writes to unmapped addresses are ignored.
- CSR write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. The write commits at the clock edge when csr_op != 00.
- FSM states are IDLE and REDIR. Reset state is IDLE.
- IDLE with trap_req_valid=1: the request is accepted at the edge and the FSM moves to REDIR.
  - ENTER:
    - mepc <= trap_req_pc & MEPC_MASK
    - mcause <= cause
    - mtval <= tval
    - MPIE <= MIE, MIE <= 0
    - redir_pc <= current (pre-edge) mtvec
  - RETURN:
    - MIE <= MPIE, MPIE <= 1
    - redir_pc <= current (pre-edge) mepc
    - mcause and mtval are unchanged.
- REDIR: redirflag=1 for exactly this one cycle. trap_req_valid is ignored (the wrong-path request is being flushed). The FSM returns to IDLE unconditionally.
- Latency: request in cycle N gives redirflag/redir_pc in cycle N+1. Back-to-back redirects are impossible; minimum spacing is 2 cycles.
- Simultaneous accepted trap and CSR write in the same cycle: the trap update wins and the whole CSR write is dropped. csr_rdata still returns the old value.
- A CSR write while in REDIR commits normally.
- mcycle:
  - 64-bit, increments every cycle, with carry from the low word into the high word.
  - A CSR write to 0xB00 or 0xB80 replaces that half for the cycle (no increment that cycle); the other half holds its value.
  - Wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Reset (asynchronous, any state, including mid-REDIR):
  - Outputs: redirflag=0, redir_pc=0, mie_o=0.
  - CSRs: mstatus MIE=0, MPIE=0; mtvec=MTVEC_RESET; mepc, mcause, mtval, mscratch, mcycle all 0.
  - FSM: IDLE.
  - A redirect pending at reset assertion is discarded.

Test Plan:
- Reset, then write mtvec=0x0000_0103 via RW -> read returns 0x0000_0100. ECALL request (cause 11, pc 0x40) -> next cycle redirflag=1, redir_pc=0x100; mepc=0x40, mcause=11; cycle after, redirflag=0.
- Set MIE via RS 0x300 with 0x8; misaligned load (cause 4, pc 0x86, tval 0x1001) -> mepc=0x84, mtval=0x1001, MIE=0, MPIE=1; then MRET -> redir_pc=0x84, MIE=1, MPIE=1.
- Request in IDLE plus a second request in the REDIR cycle -> only one redirflag pulse; CSRs reflect the first request only.
- ECALL in the same cycle as RW mepc=0xDEAD_BEEC -> mepc=trap_req_pc & MEPC_MASK; the CSR write is lost.
- Write mcycle=0xFFFF_FFFF -> next cycle mcycleh increments by 1 and mcycle=0. Write mcycleh while running -> low word continues counting.
- Assert rst the cycle after a request is accepted -> redirflag=0 immediately (asynchronous); all CSRs at reset values; no pulse after release.
